// File: rtl/word_splitter_seq_if.sv
// word_splitter_seq_if
// Handshake bundle for word_splitter_seq: the word-wide input side
// (in_valid/in_ready/in_data/in_msb_first), the lane-wide output side
// (out_valid/out_ready/out_data/out_idx/out_last) and the busy status.
//   master : producer/consumer view (drives in_*, out_ready)
//   slave  : splitter view (drives in_ready, out_*, busy)
interface word_splitter_seq_if #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
);
  localparam int NLANE = DATA_W / LANE_W;
  localparam int IDX_W = (NLANE > 1) ? $clog2(NLANE) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_msb_first;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              busy;

  modport master (
    output in_valid, in_data, in_msb_first, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, in_msb_first, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy
  );
endinterface

// File: rtl/word_splitter_seq.sv
// word_splitter_seq
// Accepts one DATA_W-bit word per input handshake and emits it as
// NLANE = DATA_W/LANE_W lanes of LANE_W bits, one lane per output handshake.
// Lane order (MSB-first or LSB-first) is captured with each word.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : word_splitter_seq_if.slave (in_valid/in_ready/in_data/in_msb_first,
//           out_valid/out_ready/out_data/out_idx/out_last, busy)
// DATA_W must be a multiple of LANE_W and at least 2*LANE_W.
module word_splitter_seq #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  word_splitter_seq_if.slave  bus
);
  localparam int NLANE = DATA_W / LANE_W;
  localparam int IDX_W = (NLANE > 1) ? $clog2(NLANE) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] word_r;
  logic              msb_r;
  logic [IDX_W-1:0]  cnt_r;
  logic              out_valid_r;
  logic              busy_r;
  logic [LANE_W-1:0] out_data_r;
  logic              out_last_r;

  logic              xfer_s;
  logic              in_ready_s;
  logic              accept_s;
  logic [IDX_W-1:0]  cnt_nxt_s;

  // Lane 'idx' in emission order of word 'w' for the given order flag.
  function automatic logic [LANE_W-1:0] lane_sel(
    input logic [DATA_W-1:0] w,
    input logic              msb,
    input logic [IDX_W-1:0]  idx
  );
    logic [LANE_W-1:0] r;
    r = {LANE_W{1'b0}};
    for (int i = 0; i < NLANE; i++) begin
      r = (idx == IDX_W'(i)) ?
          (msb ? w[DATA_W-1-i*LANE_W -: LANE_W] : w[i*LANE_W +: LANE_W]) : r;
    end
    return r;
  endfunction

  // Handshake decode; in_ready also opens on the final-lane transfer so the
  // next word can follow without a bubble.
  always_comb begin
    xfer_s     = out_valid_r && bus.out_ready;
    in_ready_s = (state_r == ST_IDLE) || (xfer_s && out_last_r);
    accept_s   = bus.in_valid && in_ready_s;
    cnt_nxt_s  = cnt_r + IDX_W'(1);
  end

  // Splitter FSM with registered lane outputs. The first lane is loaded from
  // in_data into the output register at accept, so it appears one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      word_r      <= {DATA_W{1'b0}};
      msb_r       <= 1'b0;
      cnt_r       <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= {LANE_W{1'b0}};
      out_last_r  <= 1'b0;
    end else if (accept_s) begin
      // Accept happens either in IDLE or on the last-lane transfer.
      state_r     <= ST_SEND;
      word_r      <= bus.in_data;
      msb_r       <= bus.in_msb_first;
      cnt_r       <= {IDX_W{1'b0}};
      out_valid_r <= 1'b1;
      busy_r      <= 1'b1;
      out_data_r  <= lane_sel(bus.in_data, bus.in_msb_first, {IDX_W{1'b0}});
      out_last_r  <= 1'b0;
    end else if (xfer_s) begin
      if (out_last_r) begin
        state_r     <= ST_IDLE;
        cnt_r       <= {IDX_W{1'b0}};
        out_valid_r <= 1'b0;
        busy_r      <= 1'b0;
        out_data_r  <= {LANE_W{1'b0}};
        out_last_r  <= 1'b0;
      end else begin
        cnt_r      <= cnt_nxt_s;
        out_data_r <= lane_sel(word_r, msb_r, cnt_nxt_s);
        out_last_r <= (cnt_nxt_s == IDX_W'(NLANE - 1));
      end
    end else begin
      // Stall or idle: everything holds.
      state_r <= state_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_idx   = cnt_r;
  assign bus.out_last  = out_last_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_word_splitter_seq.sv
// tb_word_splitter_seq
// Bench for word_splitter_seq: directed scenarios plus random traffic on a
// 32/8 instance checked against a queue of expected lanes, and a short
// directed check of a 16/4 instance.
module tb_word_splitter_seq;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int NL = DW / LW;

  typedef struct {
    logic [7:0] data;
    int         idx;
    logic       last;
  } lane_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total_cnt = 0;
  int   bad_cnt   = 0;
  lane_t exp_q[$];

  always #5 clk = ~clk;

  word_splitter_seq_if #(.DATA_W(32), .LANE_W(8)) bus ();
  word_splitter_seq_if #(.DATA_W(16), .LANE_W(4)) bus4 ();

  word_splitter_seq #(.DATA_W(32), .LANE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  word_splitter_seq #(.DATA_W(16), .LANE_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a word expands into NL lanes in emission order.
  task automatic push_word(input logic [31:0] d, input logic msb);
    lane_t l;
    for (int k = 0; k < NL; k++) begin
      l.data = msb ? 8'((d >> (DW - LW * (k + 1))) & 32'hFF) : 8'((d >> (LW * k)) & 32'hFF);
      l.idx  = k;
      l.last = (k == NL - 1);
      exp_q.push_back(l);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, update the model.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic msb, input logic ordy);
    logic  acc;
    logic  xf;
    lane_t l;
    bus.in_valid     = iv;
    bus.in_data      = d;
    bus.in_msb_first = msb;
    bus.out_ready    = ordy;
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    chk("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'((exp_q.size() == 0) || (ordy && exp_q.size() == 1)));
    if (exp_q.size() != 0) begin
      l = exp_q[0];
      chk("out_data", 32'(bus.out_data), 32'(l.data));
      chk("out_idx", 32'(bus.out_idx), 32'(l.idx));
      chk("out_last", 32'(bus.out_last), 32'(l.last));
    end
    acc = iv && bus.in_ready;
    xf  = bus.out_valid && ordy;
    if (xf && exp_q.size() != 0) begin
      l = exp_q.pop_front();
    end
    if (acc) begin
      push_word(d, msb);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'h0);
    chk("rst_out_last", 32'(bus.out_last), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_msb_first = 1'b0; bus.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_msb_first = 1'b0; bus4.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // MSB-first then LSB-first on the same word.
    cycle(1'b1, 32'hF1F2F3F4, 1'b1, 1'b1);
    idle(5);
    cycle(1'b1, 32'hF1F2F3F4, 1'b0, 1'b1);
    idle(5);

    // Back-to-back words with mixed order, in_valid held high.
    cycle(1'b1, 32'h11223344, 1'b1, 1'b1);
    repeat (4) cycle(1'b1, 32'hAABBCCDD, 1'b0, 1'b1);
    idle(5);

    // Backpressure while F2 is shown; in_valid pulses must be ignored.
    cycle(1'b1, 32'hF1F2F3F4, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (3) cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(4);

    // Reset after F2 transfers; F3/F4 must never appear.
    cycle(1'b1, 32'hF1F2F3F4, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 32'h01020304, 1'b1, 1'b1);
    idle(5);

    // Random traffic with random backpressure and order.
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end
    idle(8);
    chk("drained", 32'(exp_q.size()), 32'h0);

    // Narrow instance: 16/4, MSB-first.
    bus4.in_valid = 1'b1; bus4.in_data = 16'hABCD; bus4.in_msb_first = 1'b1; bus4.out_ready = 1'b1;
    @(negedge clk);
    chk("n_in_ready", 32'(bus4.in_ready), 32'h1);
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] w;
      w = 16'hABCD;
      @(negedge clk);
      chk("n_out_valid", 32'(bus4.out_valid), 32'h1);
      chk("n_out_data", 32'(bus4.out_data), 32'((w >> (16 - 4 * (k + 1))) & 16'hF));
      chk("n_out_idx", 32'(bus4.out_idx), 32'(k));
      chk("n_out_last", 32'(bus4.out_last), 32'(k == 3));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("n_idle_valid", 32'(bus4.out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule

// File: doc/word_splitter_seq.md
Name: word_splitter_seq

Overview:
- Parametrised sequential successor to the combinational word splitter: accepts one DATA_W-bit word per handshake and emits it as DATA_W/LANE_W lanes, one lane per transfer.
- Lane order is selectable per word: MSB-first (lane 0 = bits [DATA_W-1 -: LANE_W]) or LSB-first.
- Sits between a word-wide producer (register file / memory read path) and a byte-wide consumer (display, UART, checksum) with valid/ready on both sides.

Parameters:
- DATA_W, 32, input word width; must be a multiple of LANE_W and at least 2*LANE_W.
- LANE_W, 8, output lane width.
- Derived (localparam, not overridable): NLANE = DATA_W/LANE_W; IDX_W = max(1, clog2(NLANE)).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept a word this cycle
- in_data  input  DATA_W  word to split
- in_msb_first  input  1  lane order for this word: 1 = MSB-first, 0 = LSB-first
- out_valid  output  1  current lane is valid
- out_ready  input  1  consumer accepts current lane
- out_data  output  LANE_W  current lane
- out_idx  output  IDX_W  index of current lane in emission order, 0..NLANE-1
- out_last  output  1  current lane is the final lane of the word
- busy  output  1  word held, lanes still pending

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; word register, lane counter and order flag clear to 0.
  - Outputs: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
  - in_ready=1 in the first cycle after release.
  - Reset mid-word discards the word and any remaining lanes.
- FSM has two states:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: out_valid=1, busy=1.
- Accept: in_valid && in_ready at a clock edge latches in_data and in_msb_first, clears the counter and moves to SEND.
  - First lane is visible on the next cycle (latency 1). It is never combinationally forwarded from in_data.
- Lane selection, with cnt = lane counter:
  - msb_first=1: out_data = word[DATA_W-1-cnt*LANE_W -: LANE_W].
  - msb_first=0: out_data = word[cnt*LANE_W +: LANE_W].
  - out_idx = cnt; out_last = (cnt == NLANE-1) while in SEND.
- Lane transfer: out_valid && out_ready.
  - Not last lane: cnt increments.
  - Last lane: cnt returns to 0; state goes to IDLE, unless a new word is accepted in the same cycle.
- Output stall: while out_ready=0, out_data, out_idx and out_last hold stable. out_valid never drops before the lane is transferred.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - Combinational from out_ready.
  - This allows back-to-back words with no bubble: a new word accepted on the final-lane transfer stays in SEND with cnt=0 and the new data/order.
- Input changes while not accepted are ignored. in_msb_first is sampled only at accept.
- Order flag is captured per word, so consecutive words may use different orders.
- No lane may be skipped or repeated. A word always yields exactly NLANE transfers.
- Throughput: one lane per cycle with out_ready held high; NLANE cycles per word sustained.

Test Plan:
- MSB-first, default params: in_data=32'hF1F2F3F4, in_msb_first=1, out_ready=1. Required: accept at T, then lanes F1,F2,F3,F4 at T+1..T+4; out_idx 0..3; out_last only with F4; in_ready=0 during T+1..T+3.
- LSB-first: same word, in_msb_first=0. Required: F4,F3,F2,F1; out_last with F1.
- Back-to-back, mixed order: words 32'h11223344 (MSB-first) then 32'hAABBCCDD (LSB-first), in_valid held high, out_ready=1. Required: 11,22,33,44,DD,CC,BB,AA on 8 consecutive cycles, no gap.
- Backpressure: out_ready=0 for 3 cycles while lane F2 is shown. Required: out_data=F2 and out_idx=1 held, out_valid stays 1, next lane F3 only after out_ready returns to 1; in_valid pulses during the stall are not accepted.
- Reset mid-word: assert rst_n=0 after lane F2 transfers, release, then send 32'h01020304 MSB-first. Required: all outputs 0 during reset; F3/F4 are never emitted; output is 01,02,03,04.
- Parametrised instance DATA_W=16, LANE_W=4: in_data=16'hABCD, MSB-first. Required: A,B,C,D; out_idx 0..3; out_last on D.
